mem_moc_responder: RTL and testbench



---
 rtl/mem_moc_responder.sv | 202 ++++++++++++++++++++
 tb/tb_mem_moc_responder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_moc_responder.sv
// mem_moc_responder
//   Memory-side responder for the multicycle CPU's memEnable/MOC handshake.
//   It is a byte-addressed, big-endian byte array that serves byte, halfword and
//   word reads and writes. Loads can be sign- or zero-extended. A configurable
//   number of wait states is inserted before MOC is raised.
//
// Parameters
//   DEPTH        memory size in bytes (power of two, multiple of 4)
//   WAIT_CYCLES  extra wait states before MOC (0..15)
//
// Ports
//   clk        system clock, rising edge
//   Reset      synchronous, active-high reset (control state only; memory kept)
//   memEnable  request strobe, held high by the controller until MOC is seen
//   RW         0 = read, 1 = write (captured with the request)
//   address    byte address (captured; taken modulo DEPTH)
//   dataIn     write data, right-justified for byte/halfword (captured)
//   size       00 byte, 01 halfword, 10 word, 11 treated as word (captured)
//   signExt    1 = sign-extend byte/halfword loads, 0 = zero-extend (captured)
//   dataOut    last completed read value, right-justified and extended
//   MOC        memory operation complete, held until memEnable drops
//   alignErr   the completed access was misaligned (no write, dataOut = 0)
module mem_moc_responder #(
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        memEnable,
  input  logic        RW,
  input  logic [31:0] address,
  input  logic [31:0] dataIn,
  input  logic [1:0]  size,
  input  logic        signExt,
  output logic [31:0] dataOut,
  output logic        MOC,
  output logic        alignErr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [31:0]    dout_q, dout_d;
  logic           moc_q, moc_d;
  logic           aerr_q, aerr_d;

  // Request fields captured in IDLE and held for the whole transaction
  logic           rw_q;
  logic [AW-1:0]  addr_q;
  logic [31:0]    wdata_q;
  logic [1:0]     size_q;
  logic           sext_q;

  logic [7:0]     mem_q [DEPTH];

  logic           capture;
  logic           access;
  logic           wr_en;
  logic           is_byte, is_half;
  logic           misaligned;
  logic [AW-1:0]  addr1, addr2, addr3;
  logic [7:0]     b0, b1, b2, b3;
  logic [31:0]    rdata;

  // Address bits above the array size are deliberately ignored (wrap-around)
  logic           unused_addr_bits;
  assign unused_addr_bits = ^address[31:AW];

  assign capture = (state_q == IDLE) && memEnable;

  always_ff @(posedge clk) begin
    if (capture) begin
      rw_q    <= RW;
      addr_q  <= address[AW-1:0];
      wdata_q <= dataIn;
      size_q  <= size;
      sext_q  <= signExt;
    end
  end

  // Size 11 falls into the word case
  assign is_byte = (size_q == 2'b00);
  assign is_half = (size_q == 2'b01);

  assign misaligned = (is_half && addr_q[0]) ||
                      (!is_byte && !is_half && (addr_q[1:0] != 2'b00));

  assign addr1 = addr_q + AW'(1);
  assign addr2 = addr_q + AW'(2);
  assign addr3 = addr_q + AW'(3);

  // Big-endian: the lowest address holds the most significant byte
  assign b0 = mem_q[addr_q];
  assign b1 = mem_q[addr1];
  assign b2 = mem_q[addr2];
  assign b3 = mem_q[addr3];

  always_comb begin
    rdata = {b0, b1, b2, b3};
    if (is_byte) begin
      rdata = {{24{sext_q & b0[7]}}, b0};
    end else if (is_half) begin
      rdata = {{16{sext_q & b0[7]}}, b0, b1};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    moc_d   = moc_q;
    aerr_d  = aerr_q;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (memEnable) begin
          cnt_d   = WAIT_LD;
          aerr_d  = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!memEnable) begin
          // Controller withdrew the request: abandon it silently
          state_d = IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access  = 1'b1;
          moc_d   = 1'b1;
          state_d = DONE;
          if (misaligned) begin
            // Still complete the handshake so the controller never stalls
            aerr_d = 1'b1;
            dout_d = 32'h0;
          end else if (!rw_q) begin
            dout_d = rdata;
          end
        end
      end
      DONE: begin
        if (!memEnable) begin
          moc_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        moc_d   = 1'b0;
      end
    endcase
  end

  // A reset landing on the access edge must not commit the write
  assign wr_en = access && rw_q && !misaligned && !Reset;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      dout_q  <= 32'h0;
      moc_q   <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      moc_q   <= moc_d;
      aerr_q  <= aerr_d;
    end
  end

  // Storage array is never reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (is_byte) begin
        mem_q[addr_q] <= wdata_q[7:0];
      end else if (is_half) begin
        mem_q[addr_q] <= wdata_q[15:8];
        mem_q[addr1]  <= wdata_q[7:0];
      end else begin
        mem_q[addr_q] <= wdata_q[31:24];
        mem_q[addr1]  <= wdata_q[23:16];
        mem_q[addr2]  <= wdata_q[15:8];
        mem_q[addr3]  <= wdata_q[7:0];
      end
    end
  end

  assign dataOut  = dout_q;
  assign MOC      = moc_q;
  assign alignErr = aerr_q;

endmodule

// File: tb/tb_mem_moc_responder.sv
module tb_mem_moc_responder;

  localparam int DEPTH = 512;
  localparam int W     = 2;

  logic        clk = 1'b0;
  logic        Reset;
  logic        memEnable, RW, signExt;
  logic [31:0] address, dataIn;
  logic [1:0]  size;
  logic [31:0] dataOut;
  logic        MOC, alignErr;

  logic        me0, rw0, sx0;
  logic [31:0] addr0, din0;
  logic [1:0]  sz0;
  logic [31:0] dout0;
  logic        moc0, aerr0;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_last;
  logic [7:0]  model_mem [DEPTH];

  always #5 clk = ~clk;

  mem_moc_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk(clk), .Reset(Reset), .memEnable(memEnable), .RW(RW),
    .address(address), .dataIn(dataIn), .size(size), .signExt(signExt),
    .dataOut(dataOut), .MOC(MOC), .alignErr(alignErr)
  );

  mem_moc_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .Reset(Reset), .memEnable(me0), .RW(rw0),
    .address(addr0), .dataIn(din0), .size(sz0), .signExt(sx0),
    .dataOut(dout0), .MOC(moc0), .alignErr(aerr0)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  // Returns {alignErr, dataOut} the spec's rules require for a read
  function automatic logic [32:0] model_read(input logic [31:0] a, input logic [1:0] sz,
                                             input logic sx);
    int n = nbytes(sz);
    int base = int'(a % DEPTH);
    longint unsigned v = 0;
    if ((a % n) != 0) return {1'b1, 32'h0};
    for (int k = 0; k < n; k++) v = (v << 8) | longint'(model_mem[(base + k) % DEPTH]);
    if (sx && n < 4 && (((v >> (8 * n - 1)) & 1) == 1))
      v = v | (64'hFFFF_FFFF << (8 * n));
    return {1'b0, v[31:0]};
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                      input logic [1:0] sz);
    int n = nbytes(sz);
    int base = int'(a % DEPTH);
    if ((a % n) != 0) return;
    for (int k = 0; k < n; k++)
      model_mem[(base + k) % DEPTH] = 8'((d >> (8 * (n - 1 - k))) & 32'hFF);
  endfunction

  task automatic do_req(input logic rw_v, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input logic sx,
                        input logic [31:0] exp_d, input logic exp_e,
                        input bit chk, input string nm);
    int n;
    memEnable = 1'b1; RW = rw_v; address = a; dataIn = d; size = sz; signExt = sx;
    @(negedge clk);
    n = 0;
    while (!MOC && n < 40) begin
      @(negedge clk);
      n++;
    end
    // Later input changes must be ignored
    address = $urandom; dataIn = $urandom; RW = ~rw_v; size = ~sz;
    if (chk) begin
      check({nm, "_lat"}, 32'(n), 32'(W + 1));
      check({nm, "_dout"}, dataOut, exp_d);
      check({nm, "_aerr"}, {31'h0, alignErr}, {31'h0, exp_e});
    end
    memEnable = 1'b0;
    @(negedge clk);
    if (chk) check({nm, "_mocdrop"}, {31'h0, MOC}, 32'h0);
  endtask

  task automatic zreq(input logic rw_v, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_d, input string nm);
    me0 = 1'b1; rw0 = rw_v; addr0 = a; din0 = d; sz0 = 2'd2; sx0 = 1'b0;
    @(negedge clk);
    check({nm, "_cap"}, {31'h0, moc0}, 32'h0);
    @(negedge clk);
    check({nm, "_moc"}, {31'h0, moc0}, 32'h1);
    check({nm, "_dout"}, dout0, exp_d);
    me0 = 1'b0;
    @(negedge clk);
    check({nm, "_drop"}, {31'h0, moc0}, 32'h0);
  endtask

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] din;
    logic [1:0]  sz;
    logic        sx;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;

  vec_t vecs [19];

  initial begin
    logic [32:0] mr;
    logic [31:0] a, d, held;
    logic [1:0]  sz;
    logic        rw_v, sx;
    int          n;

    // Preload pattern: byte at index i holds i[7:0]^8'h3C
    vecs[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 2'd2, 1'b0, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,       32'h0,        2'd2, 1'b0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b0, 32'h10,       32'h0,        2'd0, 1'b0, 32'h000000DE, 1'b0};
    vecs[3]  = '{1'b1, 32'h21,       32'h12345680, 2'd0, 1'b0, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 32'h21,       32'h0,        2'd0, 1'b1, 32'hFFFFFF80, 1'b0};
    vecs[5]  = '{1'b0, 32'h21,       32'h0,        2'd0, 1'b0, 32'h00000080, 1'b0};
    vecs[6]  = '{1'b0, 32'h20,       32'h0,        2'd2, 1'b0, 32'h1C801E1F, 1'b0};
    vecs[7]  = '{1'b0, 32'h13,       32'h0,        2'd2, 1'b0, 32'h0,        1'b1};
    vecs[8]  = '{1'b1, 32'h13,       32'hCAFEF00D, 2'd2, 1'b0, 32'h0,        1'b1};
    vecs[9]  = '{1'b0, 32'h10,       32'h0,        2'd2, 1'b0, 32'hDEADBEEF, 1'b0};
    vecs[10] = '{1'b0, 32'h14,       32'h0,        2'd2, 1'b0, 32'h28292A2B, 1'b0};
    vecs[11] = '{1'b1, 32'h30,       32'hFFFF8001, 2'd1, 1'b0, 32'h0,        1'b0};
    vecs[12] = '{1'b0, 32'h30,       32'h0,        2'd1, 1'b1, 32'hFFFF8001, 1'b0};
    vecs[13] = '{1'b0, 32'h30,       32'h0,        2'd1, 1'b0, 32'h00008001, 1'b0};
    vecs[14] = '{1'b0, 32'h30,       32'h0,        2'd2, 1'b0, 32'h80010E0F, 1'b0};
    vecs[15] = '{1'b0, 32'h31,       32'h0,        2'd1, 1'b1, 32'h0,        1'b1};
    vecs[16] = '{1'b0, 32'hFFFFFE10, 32'h0,        2'd3, 1'b1, 32'hDEADBEEF, 1'b0};
    vecs[17] = '{1'b0, 32'h32,       32'h0,        2'd1, 1'b1, 32'h00000E0F, 1'b0};
    vecs[18] = '{1'b0, 32'h22,       32'h0,        2'd0, 1'b1, 32'h0000001E, 1'b0};

    Reset = 1'b1; memEnable = 1'b0; RW = 1'b0; address = 32'h0; dataIn = 32'h0;
    size = 2'd0; signExt = 1'b0;
    me0 = 1'b0; rw0 = 1'b0; addr0 = 32'h0; din0 = 32'h0; sz0 = 2'd0; sx0 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_moc", {31'h0, MOC}, 32'h0);
    check("rst_dout", dataOut, 32'h0);
    check("rst_aerr", {31'h0, alignErr}, 32'h0);
    check("rst_moc0", {31'h0, moc0}, 32'h0);

    // Reset and request together: reset wins
    memEnable = 1'b1;
    @(negedge clk);
    Reset = 1'b0; memEnable = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_req_moc", {31'h0, MOC}, 32'h0);

    for (int i = 0; i < DEPTH; i += 4) begin
      d = {8'(i) ^ 8'h3C, 8'(i + 1) ^ 8'h3C, 8'(i + 2) ^ 8'h3C, 8'(i + 3) ^ 8'h3C};
      do_req(1'b1, 32'(i), d, 2'd2, 1'b0, 32'h0, 1'b0, 1'b0, "pre");
      model_write(32'(i), d, 2'd2);
    end
    exp_last = 32'h0;

    for (int i = 0; i < 19; i++) begin
      logic [31:0] e;
      e = vecs[i].rw ? (vecs[i].exp_e ? 32'h0 : exp_last) : vecs[i].exp_d;
      do_req(vecs[i].rw, vecs[i].addr, vecs[i].din, vecs[i].sz, vecs[i].sx,
             e, vecs[i].exp_e, 1'b1, $sformatf("vec%0d", i));
      exp_last = e;
      if (vecs[i].rw) model_write(vecs[i].addr, vecs[i].din, vecs[i].sz);
    end

    // Cancel during WAIT: no MOC, no write, dataOut kept
    memEnable = 1'b1; RW = 1'b1; address = 32'h40; dataIn = 32'h55AA55AA; size = 2'd2;
    repeat (3) @(negedge clk);
    memEnable = 1'b0;
    @(negedge clk);
    check("cancel_moc", {31'h0, MOC}, 32'h0);
    @(negedge clk);
    check("cancel_moc2", {31'h0, MOC}, 32'h0);
    check("cancel_dout", dataOut, exp_last);
    do_req(1'b0, 32'h40, 32'h0, 2'd2, 1'b0, 32'h7C7D7E7F, 1'b0, 1'b1, "cancel_rd");
    exp_last = 32'h7C7D7E7F;

    // Reset on the access edge: write aborted, outputs cleared
    do_req(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1, "prerst_rd");
    memEnable = 1'b1; RW = 1'b1; address = 32'h40; dataIn = 32'h55AA55AA; size = 2'd2;
    repeat (3) @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    check("midrst_moc", {31'h0, MOC}, 32'h0);
    check("midrst_dout", dataOut, 32'h0);
    check("midrst_aerr", {31'h0, alignErr}, 32'h0);
    Reset = 1'b0; memEnable = 1'b0;
    @(negedge clk);
    exp_last = 32'h0;
    do_req(1'b0, 32'h40, 32'h0, 2'd2, 1'b0, 32'h7C7D7E7F, 1'b0, 1'b1, "midrst_rd");
    exp_last = 32'h7C7D7E7F;

    // Wrap-around write then a long MOC hold
    do_req(1'b1, 32'h204, 32'h12345678, 2'd2, 1'b0, exp_last, 1'b0, 1'b1, "wrap_wr");
    model_write(32'h204, 32'h12345678, 2'd2);
    memEnable = 1'b1; RW = 1'b0; address = 32'h4; size = 2'd2; signExt = 1'b0;
    @(negedge clk);
    n = 0;
    while (!MOC && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("wrap_lat", 32'(n), 32'(W + 1));
    check("wrap_rd", dataOut, 32'h12345678);
    held = dataOut;
    for (int k = 0; k < 5; k++) begin
      address = $urandom; RW = 1'b1; dataIn = $urandom;
      @(negedge clk);
      check($sformatf("hold_moc%0d", k), {31'h0, MOC}, 32'h1);
      check($sformatf("hold_dout%0d", k), dataOut, 32'h12345678);
    end
    memEnable = 1'b0;
    @(negedge clk);
    check("hold_drop", {31'h0, MOC}, 32'h0);
    exp_last = held;
    do_req(1'b0, 32'h14, 32'h0, 2'd2, 1'b0, 32'h28292A2B, 1'b0, 1'b1, "hold_nowr");
    exp_last = 32'h28292A2B;

    // Randomized accesses against the byte-array model
    for (int i = 0; i < 150; i++) begin
      rw_v = 1'($urandom);
      sz   = 2'($urandom);
      sx   = 1'($urandom);
      a    = $urandom;
      d    = $urandom;
      if ($urandom_range(0, 2) != 0) a = a & ~32'(nbytes(sz) - 1);
      mr = model_read(a, sz, sx);
      if (rw_v) begin
        mr[31:0] = mr[32] ? 32'h0 : exp_last;
      end
      do_req(rw_v, a, d, sz, sx, mr[31:0], mr[32], 1'b1, $sformatf("rnd%0d", i));
      exp_last = mr[31:0];
      if (rw_v) model_write(a, d, sz);
    end

    // Zero wait states: back-to-back accesses with a one-cycle gap
    for (int i = 0; i < 4; i++)
      zreq(1'b1, 32'h100 + 32'(4 * i), 32'hA0B0C0D0 + 32'(i * 32'h01010101), 32'h0,
           $sformatf("z_wr%0d", i));
    for (int i = 0; i < 4; i++)
      zreq(1'b0, 32'h100 + 32'(4 * i), 32'h0, 32'hA0B0C0D0 + 32'(i * 32'h01010101),
           $sformatf("z_rd%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
